// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and slice width.
package nibble_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rippleadd.sv
// 4-bit ripple-carry adder used as the single slice datapath.
module rippleadd (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       cout,
    output logic [3:0] sum
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, chained through carry.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one 4-bit slice per clock, using a single rippleadd.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

    assign a_slice    = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign b_slice    = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == IDX_LAST);

    rippleadd u_slice (
        .cin  (carry_q),
        .a    (a_slice),
        .b    (b_slice),
        .cout (slice_cout),
        .sum  (slice_sum)
    );

    // State and datapath registers; reset wins over any start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state: start only matters in IDLE, DONE always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_slice) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, one slice per RUN cycle.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (last_slice) begin
                    cout_d = slice_cout;
                    idx_d  = '0;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized bench for nibble_serial_adder with an expected-result queue.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    localparam int NIB = 4;
    localparam int W   = SLICE_W * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] op_a, op_b;
    logic         op_cin;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a start request and record the reference result.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin);
        logic [W:0] full;
        start  = 1'b1;
        a      = ia;
        b      = ib;
        cin    = icin;
        op_a   = ia;
        op_b   = ib;
        op_cin = icin;
        full   = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
        exp_q.push_back(full);
    endtask

    // Called just after the accepting edge; walks the operation to IDLE.
    task automatic finish_op(input logic hold, input logic scramble);
        logic [W:0] e;
        chk("accept_busy", {31'b0, busy}, 1);
        chk("accept_done", {31'b0, done}, 0);
        start = hold;
        for (int k = 1; k < NIB; k++) begin
            if (scramble) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            tick();
            chk("run_busy", {31'b0, busy}, 1);
            chk("run_done", {31'b0, done}, 0);
        end
        tick();
        chk("done_busy", {31'b0, busy}, 0);
        chk("done_pulse", {31'b0, done}, 1);
        chk("queue_nonempty", {31'b0, (exp_q.size() != 0)}, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("sum", {16'b0, sum}, {16'b0, e[W-1:0]});
        chk("cout", {31'b0, cout}, {31'b0, e[W]});
        $display("op a=%h b=%h cin=%b -> sum=%h cout=%b", op_a, op_b, op_cin, sum, cout);
        tick();
        chk("idle_busy", {31'b0, busy}, 0);
        chk("idle_done", {31'b0, done}, 0);
        chk("hold_sum", {16'b0, sum}, {16'b0, e[W-1:0]});
        chk("hold_cout", {31'b0, cout}, {31'b0, e[W]});
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          input logic hold, input logic scramble);
        issue(ia, ib, icin);
        tick();
        finish_op(hold, scramble);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        start = 1'b1;
        a     = 16'h1234;
        tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_sum", {16'b0, sum}, 0);
        chk("rst_cout", {31'b0, cout}, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op(16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(16'h1234, 16'h0F0F, 1'b1, 1'b1, 1'b1);

        // Reset on the second RUN edge aborts without a done pulse.
        start = 1'b1;
        a     = 16'h5555;
        b     = 16'h3333;
        cin   = 1'b1;
        tick();
        chk("abort_accept", {31'b0, busy}, 1);
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_sum", {16'b0, sum}, 0);
        chk("abort_cout", {31'b0, cout}, 0);
        rst = 1'b0;
        issue(16'h000F, 16'h0001, 1'b0);
        tick();
        finish_op(1'b0, 1'b0);

        // Randomized operations with random hold/scramble and idle gaps.
        for (int n = 0; n < 200; n++) begin
            int gap;
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_busy", {31'b0, busy}, 0);
                chk("gap_done", {31'b0, done}, 0);
            end
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an addition, sampled only in IDLE.
REQ-005 SHALL have port: a  input  W  operand A, captured when start is accepted.
REQ-006 SHALL have port: b  input  W  operand B, captured when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while slices are being added (state RUN).
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: sum  output  W  result register.
REQ-011 SHALL have port: cout  output  1  final carry-out register.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL transition IDLE->RUN on an edge with start=1, latching a, b and cin into internal registers, clearing sum and cout to 0, and setting slice index to 0.
REQ-014 SHALL, on each RUN edge, add slice idx of latched A and B plus the carry register via one 4-bit adder, write the 4-bit result into sum[4*idx+3:4*idx], store the adder carry-out into the carry register, and increment idx.
REQ-015 SHALL transition RUN->DONE on the edge processing idx = NIBBLES-1, loading cout with that slice's carry-out.
REQ-016 SHALL transition DONE->IDLE unconditionally on the next edge.
REQ-017 SHALL drive busy = (state==RUN) and done = (state==DONE), so done is high for exactly one cycle, NIBBLES edges after the accepting edge; throughput is one operation per NIBBLES+2 cycles.
REQ-018 SHALL ignore start in RUN and DONE, with no effect on the operation in progress and no queuing.
REQ-019 SHALL keep the a, b and cin inputs without effect except at the accepting edge; later input changes do not alter the result.
REQ-020 SHALL hold sum and cout stable from DONE until the next accepted start.
REQ-021 SHALL compute sum = (A + B + cin) mod 2^W and cout = bit W of the full-width sum, with no overflow flagging.
REQ-022 SHALL propagate carry correctly across all slices, including a full-length ripple (e.g. all-ones + 1).

Reset
REQ-023 SHALL, when rst=1 at a clock edge, force state IDLE, idx 0, carry register 0, latched operands 0, sum 0, cout 0, busy 0 and done 0, with priority over start.
REQ-024 SHALL abort an operation on reset mid-RUN or in DONE with no done pulse, and SHALL accept a start asserted on the first edge after rst deasserts.

Structure
REQ-025 SHALL place state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) and the slice width constant 4 in a shared include or package used by this block and its bench.
REQ-026 SHALL instantiate the existing 4-bit ripple-carry adder rippleadd (port order cin, a, b, cout, sum) exactly once as the slice datapath, with no other arithmetic on operand data.
REQ-027 SHALL size idx as clog2(NIBBLES), with a minimum of 1 bit.

Verification (NIBBLES=4)
REQ-028 SHALL cover: a=0x0000, b=0x0000, cin=0 -> done 4 edges after accept, sum=0x0000, cout=0.
REQ-029 SHALL cover: a=0xAAAA, b=0xAAAA, cin=0 -> sum=0x5554, cout=1.
REQ-030 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (full ripple); then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-031 SHALL cover: a=0x1234, b=0x0F0F, cin=1; start held high and operands changed during RUN -> single done pulse, sum=0x2144, cout=0, no second operation started before IDLE.
REQ-032 SHALL cover: rst pulsed on 2nd RUN edge -> busy=0, sum=0, cout=0, no done pulse; a new start with a=0x000F, b=0x0001, cin=0 -> sum=0x0010, cout=0.
REQ-033 SHALL cover: a randomized run of 200 operations checked against the reference model (A + B + cin), with busy/done timing checked each cycle.
